mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory command port between the
// instruction-fetch and data stages. Data normally wins contention, but a
// streak counter hands the port to a waiting fetch after MAX_DSTREAK data
// grants. A wait counter forces completion with rdata=0 and raises a sticky
// bus_err when the memory never acknowledges. All state moves on the falling
// edge of CLK so results are ready for the pipeline's rising edge.
module mem_port_arbiter #(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } stateT;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0] WAIT_LAST  = 8'(ACK_TIMEOUT - 1);

  stateT       state;
  stateT       nextState;
  logic [3:0]  dStreak;
  logic [7:0]  waitCnt;
  logic        ifElig;
  logic        dElig;
  logic        grantData;
  logic        grantFetch;
  logic        finish;
  logic        timedOut;
  logic        unusedAddrBits;

  // The byte-offset bits are dropped when forming the word address.
  assign unusedAddrBits = ^{if_addr[1:0], d_addr[1:0]};

  // A requester that is completing this cycle cannot be granted again.
  assign ifElig = if_req & ~if_ready;
  assign dElig  = d_req & ~d_ready;

  // Stall whenever a stage is asking and its answer is not on the bus yet.
  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

  // Arbitration and completion decode: data wins unless the fetch side has
  // waited through a full streak; an access ends on ack or on timeout.
  always_comb begin
    nextState  = state;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    finish     = 1'b0;
    timedOut   = 1'b0;
    case (state)
      IDLE: begin
        if (dElig && (!ifElig || dStreak != STREAK_MAX)) begin
          grantData = 1'b1;
          nextState = D_WAIT;
        end else if (ifElig) begin
          grantFetch = 1'b1;
          nextState  = IF_WAIT;
        end
      end
      IF_WAIT, D_WAIT: begin
        if (mem_ack) begin
          finish    = 1'b1;
          nextState = IDLE;
        end else if (waitCnt == WAIT_LAST) begin
          finish    = 1'b1;
          timedOut  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(negedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Command capture, completion pulses, response data, wait counter and the
  // sticky error flag.
  always_ff @(negedge CLK) begin
    if (Reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
      waitCnt   <= 8'h0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grantData) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= {d_addr[31:2], 2'b00};
        mem_wdata <= d_wdata;
        waitCnt   <= 8'h0;
      end else if (grantFetch) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {if_addr[31:2], 2'b00};
        mem_wdata <= 32'h0;
        waitCnt   <= 8'h0;
      end else if (finish) begin
        mem_req <= 1'b0;
        if (state == IF_WAIT) begin
          if_ready <= 1'b1;
          if_rdata <= timedOut ? 32'h0 : mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (!mem_we) begin
            d_rdata <= timedOut ? 32'h0 : mem_rdata;
          end
        end
        if (timedOut) begin
          bus_err <= 1'b1;
          waitCnt <= waitCnt + 8'd1;
        end
      end else if (state != IDLE) begin
        waitCnt <= waitCnt + 8'd1;
      end
    end
  end

  // Data-grant streak counter used by the fetch starvation guard.
  always_ff @(negedge CLK) begin
    if (Reset) begin
      dStreak <= 4'h0;
    end else if (grantFetch) begin
      dStreak <= 4'h0;
    end else if (grantData) begin
      if (!if_req) begin
        dStreak <= 4'h0;
      end else if (dStreak != STREAK_MAX) begin
        dStreak <= dStreak + 4'd1;
      end
    end else if (state == IDLE && !if_req) begin
      dStreak <= 4'h0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter, checked every cycle
// against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int ACK_TIMEOUT = 16;
  localparam int MAX_DSTREAK = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        bus_err;

  mem_port_arbiter #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), the
  // command on the bus, the cycle of the grant and the visible results.
  int          mOwner = 0;
  logic        mReq = 1'b0;
  logic        mWe = 1'b0;
  logic [31:0] mAddr = 32'h0;
  logic [31:0] mWdata = 32'h0;
  logic        mIfReady = 1'b0;
  logic        mDReady = 1'b0;
  logic [31:0] mIfRdata = 32'h0;
  logic [31:0] mDRdata = 32'h0;
  logic        mBusErr = 1'b0;
  int          mStreak = 0;
  int          cyc = 0;
  int          grantCyc = 0;
  int          ackDelay = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic checkAll();
    checkOutput("mem_req",   32'(mem_req),   32'(mReq));
    checkOutput("mem_we",    32'(mem_we),    32'(mWe));
    checkOutput("mem_addr",  mem_addr,       mAddr);
    checkOutput("mem_wdata", mem_wdata,      mWdata);
    checkOutput("if_ready",  32'(if_ready),  32'(mIfReady));
    checkOutput("d_ready",   32'(d_ready),   32'(mDReady));
    checkOutput("if_rdata",  if_rdata,       mIfRdata);
    checkOutput("d_rdata",   d_rdata,        mDRdata);
    checkOutput("if_stall",  32'(if_stall),  32'(if_req & ~mIfReady));
    checkOutput("d_stall",   32'(d_stall),   32'(d_req & ~mDReady));
    checkOutput("bus_err",   32'(bus_err),   32'(mBusErr));
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic modelStep();
    logic newIfReady;
    logic newDReady;
    logic ifWants;
    logic dWants;
    cyc++;
    if (Reset) begin
      mOwner = 0; mReq = 0; mWe = 0; mAddr = 0; mWdata = 0;
      mIfReady = 0; mDReady = 0; mIfRdata = 0; mDRdata = 0;
      mBusErr = 0; mStreak = 0;
      return;
    end
    newIfReady = 1'b0;
    newDReady  = 1'b0;
    if (mOwner == 0) begin
      ifWants = if_req && !mIfReady;
      dWants  = d_req && !mDReady;
      if (dWants && !(ifWants && mStreak == MAX_DSTREAK)) begin
        mOwner = 2; grantCyc = cyc; mReq = 1;
        mWe = d_we; mAddr = d_addr & ~32'h3; mWdata = d_wdata;
        if (if_req) mStreak = (mStreak < MAX_DSTREAK) ? mStreak + 1 : MAX_DSTREAK;
        else        mStreak = 0;
      end else if (ifWants) begin
        mOwner = 1; grantCyc = cyc; mReq = 1;
        mWe = 0; mAddr = if_addr & ~32'h3; mWdata = 0;
        mStreak = 0;
      end else if (!if_req) begin
        mStreak = 0;
      end
    end else if (mem_ack || (cyc - grantCyc) >= ACK_TIMEOUT) begin
      if (mOwner == 1) begin
        newIfReady = 1'b1;
        mIfRdata = mem_ack ? mem_rdata : 32'h0;
      end else begin
        newDReady = 1'b1;
        if (!mWe) mDRdata = mem_ack ? mem_rdata : 32'h0;
      end
      if (!mem_ack) mBusErr = 1'b1;
      mReq = 0;
      mOwner = 0;
    end
    mIfReady = newIfReady;
    mDReady  = newDReady;
  endtask

  // Drive one cycle of inputs away from the falling (active) edge, check the
  // DUT against the model, then let the falling edge happen and step.
  task automatic applyStimulus(input logic rst, input logic ifReq,
                               input logic [31:0] ifAddr, input logic dReq,
                               input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic ack,
                               input logic [31:0] rdata, input bit doCheck);
    @(posedge CLK);
    Reset = rst; if_req = ifReq; if_addr = ifAddr;
    d_req = dReq; d_we = dWe; d_addr = dAddr; d_wdata = dWdata;
    mem_ack = ack; mem_rdata = rdata;
    #1;
    if (doCheck) checkAll();
    @(negedge CLK);
    modelStep();
  endtask

  initial begin
    logic ack;
    int waitIdx;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Fetch read with a one-cycle ack: latency 2, word-aligned address.
    applyStimulus(0, 1, 32'h43, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h43, 0, 0, 0, 0, 1, 32'h2402_0005, 1);
    applyStimulus(0, 1, 32'h43, 0, 0, 0, 0, 0, 32'h1111_1111, 1);
    checkOutput("fetchRdata", if_rdata, 32'h2402_0005);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Contention: data write first, fetch granted in the d_ready cycle.
    applyStimulus(0, 1, 32'h80, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 1);
    applyStimulus(0, 1, 32'h80, 1, 1, 32'h10, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 1);
    checkOutput("contWriteAddr", mem_addr, 32'h10);
    applyStimulus(0, 1, 32'h80, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 1);
    applyStimulus(0, 1, 32'h80, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 1);
    checkOutput("contFetchAddr", mem_addr, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Both requesters held with immediate acks: arbitration order per model.
    for (int i = 0; i < 18; i++)
      applyStimulus(0, 1, 32'h200 + 32'(i * 4), 1, 0, 32'h300 + 32'(i * 4),
                    32'(i), (mOwner != 0), $urandom, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Timeout on a data read, then a stray late ack, then reset clears bus_err.
    applyStimulus(0, 0, 0, 1, 0, 32'h104, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
    checkOutput("busErrSticky", 32'(bus_err), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("busErrCleared", 32'(bus_err), 32'h0);

    // Reset during the second D_WAIT cycle abandons the access.
    applyStimulus(0, 0, 0, 1, 1, 32'h400, 32'hCAFE_0001, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 32'h400, 32'hCAFE_0001, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 1, 32'h400, 32'hCAFE_0001, 0, 0, 1);
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0, 1, 32'h7777_0000, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with a bounded-delay memory and stray acks.
    for (int i = 0; i < 2000; i++) begin
      if (mOwner != 0) begin
        waitIdx = cyc + 1 - grantCyc;
        if (waitIdx == 1) ackDelay = $urandom_range(0, 5);
        ack = (waitIdx == ackDelay + 1);
      end else begin
        ack = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(($urandom_range(0, 249) == 0),
                    ($urandom_range(0, 3) != 0), $urandom,
                    ($urandom_range(0, 4) < 3), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, ack, $urandom, 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
